// File: rtl/multi_cycle_control_pkg.sv
// multi_cycle_control_pkg: shared opcodes, state encodings, ALUOp codes and decode helpers
package multi_cycle_control_pkg;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_FUNC = 4'd15;
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEM_ADDR;
            OP_R:         return S_EXEC_R;
            OP_BEQ:       return S_BRANCH;
            OP_J:         return S_JUMP;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: return S_EXEC_I;
            default:      return S_TRAP;
        endcase
    endfunction
    function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
        return op == OP_SLTI ? ALU_SLT :
               op == OP_ANDI ? ALU_AND :
               op == OP_ORI  ? ALU_OR  :
               op == OP_XORI ? ALU_XOR : ALU_ADD;
    endfunction
endpackage

// File: rtl/multi_cycle_control_output_decode.sv
// mcc_output_decode: per-state control outputs with handshake/branch gating and reset strobe masking
module mcc_output_decode
    import multi_cycle_control_pkg::*;
(
    input  state_t      state,
    input  logic        rst,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic [5:0]  opcode,
    output logic        pc_en,
    output logic        iord,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic        sign_extend,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  pc_source
);
    always_comb begin
        pc_en       = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        sign_extend = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = ALU_AND;
        pc_source   = 2'b00;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                sign_extend = 1'b1;
                alu_op      = ALU_ADD;
            end
            S_MEM_ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                sign_extend = 1'b1;
                alu_op      = ALU_ADD;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNC;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_op      = imm_alu_op(opcode);
                sign_extend = opcode inside {OP_ADDI, OP_ADDIU, OP_SLTI};
            end
            S_I_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                pc_en     = zero;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end
endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle MIPS-style control FSM with sticky illegal flag and retire counter
module multi_cycle_control
    import multi_cycle_control_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCEn,
    output logic        IorD,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        SignExtend,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  State,
    output logic        Illegal,
    output logic [31:0] InstrCount
);
    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        retire;
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = decode_next(Opcode);
            S_MEM_ADDR: state_d = Opcode == OP_SW ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = MemReady ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = MemReady ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
        retire        = state_d == S_FETCH &&
                        state_q inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP};
        illegal_d     = illegal_q | (state_d == S_TRAP);
        instr_count_d = instr_count_q + {31'd0, retire};
    end
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= S_FETCH;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end
    mcc_output_decode u_decode (
        .state       (state_q),
        .rst         (Reset),
        .mem_ready   (MemReady),
        .zero        (Zero),
        .opcode      (Opcode),
        .pc_en       (PCEn),
        .iord        (IorD),
        .ir_write    (IRWrite),
        .mem_read    (MemRead),
        .mem_write   (MemWrite),
        .reg_dst     (RegDst),
        .mem_to_reg  (MemToReg),
        .reg_write   (RegWrite),
        .alu_src_a   (ALUSrcA),
        .sign_extend (SignExtend),
        .alu_src_b   (ALUSrcB),
        .alu_op      (ALUOp),
        .pc_source   (PCSource)
    );
    assign State      = state_q;
    assign Illegal    = illegal_q;
    assign InstrCount = instr_count_q;
endmodule
